// File: rtl/vga_text_label.sv
// vga_text_label: overlays a short fixed-font text label on a VGA raster.
//
// Purpose: compares the current pixel coordinate against NCHAR character
// slots laid out horizontally from a programmable origin and produces a
// registered pixel-on flag, two clocks after the coordinate is presented.
//
// Ports:
//   CLK            pixel clock (only clock)
//   RESET          synchronous active-high reset
//   VGA_horzCoord  current pixel column (12 bits)
//   VGA_vertCoord  current pixel row (12 bits)
//   LBL_WR         write strobe: LBL_CODE -> slot LBL_IDX
//   LBL_IDX        slot index (indices >= NCHAR are ignored)
//   LBL_CODE       6-bit character code
//   POS_WR         origin write strobe
//   POS_X, POS_Y   new origin
//   BLINK          blink request (only used in the blink build)
//   CONDITION      registered pixel-on flag
//
// Build option: define VGA_LABEL_BLINK_EN to add a frame counter that blanks
// the label every other 2^BLINK_LOG2 frames while BLINK is high.
module vga_text_label #(
  parameter int NCHAR      = 4,
  parameter int SCALE_LOG2 = 0,
  parameter int CHAR_GAP   = 1,
  parameter int X0         = 208,
  parameter int Y0         = 940,
  parameter int BLINK_LOG2 = 5
) (
  input  logic        CLK,
  input  logic        RESET,
  input  logic [11:0] VGA_horzCoord,
  input  logic [11:0] VGA_vertCoord,
  input  logic        LBL_WR,
  input  logic [3:0]  LBL_IDX,
  input  logic [5:0]  LBL_CODE,
  input  logic        POS_WR,
  input  logic [11:0] POS_X,
  input  logic [11:0] POS_Y,
  input  logic        BLINK,
  output logic        CONDITION
);

  localparam int          PITCH   = (5 + CHAR_GAP) << SCALE_LOG2;
  localparam logic [12:0] GLYPH_W = 13'(5 << SCALE_LOG2);
  localparam logic [12:0] GLYPH_H = 13'(7 << SCALE_LOG2);

  // 5x7 font, row 0 first, bit 4 of each row is the leftmost column.
  function automatic logic [34:0] glyph(input logic [5:0] code);
    logic [34:0] g;
    case (code)
      6'd1:  g = {5'h0E, 5'h11, 5'h13, 5'h15, 5'h19, 5'h11, 5'h0E};
      6'd2:  g = {5'h04, 5'h0C, 5'h04, 5'h04, 5'h04, 5'h04, 5'h0E};
      6'd3:  g = {5'h0E, 5'h11, 5'h01, 5'h02, 5'h04, 5'h08, 5'h1F};
      6'd4:  g = {5'h1F, 5'h02, 5'h04, 5'h02, 5'h01, 5'h11, 5'h0E};
      6'd5:  g = {5'h02, 5'h06, 5'h0A, 5'h12, 5'h1F, 5'h02, 5'h02};
      6'd6:  g = {5'h1F, 5'h10, 5'h1E, 5'h01, 5'h01, 5'h11, 5'h0E};
      6'd7:  g = {5'h06, 5'h08, 5'h10, 5'h1E, 5'h11, 5'h11, 5'h0E};
      6'd8:  g = {5'h1F, 5'h01, 5'h02, 5'h04, 5'h08, 5'h08, 5'h08};
      6'd9:  g = {5'h0E, 5'h11, 5'h11, 5'h0E, 5'h11, 5'h11, 5'h0E};
      6'd10: g = {5'h0E, 5'h11, 5'h11, 5'h0F, 5'h01, 5'h02, 5'h0C};
      6'd11: g = {5'h0E, 5'h11, 5'h11, 5'h1F, 5'h11, 5'h11, 5'h11};
      6'd12: g = {5'h1E, 5'h11, 5'h11, 5'h1E, 5'h11, 5'h11, 5'h1E};
      6'd13: g = {5'h0E, 5'h11, 5'h10, 5'h10, 5'h10, 5'h11, 5'h0E};
      6'd14: g = {5'h1C, 5'h12, 5'h11, 5'h11, 5'h11, 5'h12, 5'h1C};
      6'd15: g = {5'h1F, 5'h10, 5'h10, 5'h1E, 5'h10, 5'h10, 5'h1F};
      6'd16: g = {5'h1F, 5'h10, 5'h10, 5'h1E, 5'h10, 5'h10, 5'h10};
      6'd17: g = {5'h0E, 5'h11, 5'h10, 5'h17, 5'h11, 5'h11, 5'h0F};
      6'd18: g = {5'h11, 5'h11, 5'h11, 5'h1F, 5'h11, 5'h11, 5'h11};
      6'd19: g = {5'h0E, 5'h04, 5'h04, 5'h04, 5'h04, 5'h04, 5'h0E};
      6'd20: g = {5'h07, 5'h02, 5'h02, 5'h02, 5'h02, 5'h12, 5'h0C};
      6'd21: g = {5'h11, 5'h12, 5'h14, 5'h18, 5'h14, 5'h12, 5'h11};
      6'd22: g = {5'h10, 5'h10, 5'h10, 5'h10, 5'h10, 5'h10, 5'h1F};
      6'd23: g = {5'h11, 5'h1B, 5'h15, 5'h15, 5'h11, 5'h11, 5'h11};
      6'd24: g = {5'h11, 5'h11, 5'h19, 5'h15, 5'h13, 5'h11, 5'h11};
      6'd25: g = {5'h0E, 5'h11, 5'h11, 5'h11, 5'h11, 5'h11, 5'h0E};
      6'd26: g = {5'h1E, 5'h11, 5'h11, 5'h1E, 5'h10, 5'h10, 5'h10};
      6'd27: g = {5'h0E, 5'h11, 5'h11, 5'h11, 5'h15, 5'h12, 5'h0D};
      6'd28: g = {5'h1E, 5'h11, 5'h11, 5'h1E, 5'h14, 5'h12, 5'h11};
      6'd29: g = {5'h0F, 5'h10, 5'h10, 5'h0E, 5'h01, 5'h01, 5'h1E};
      6'd30: g = {5'h1F, 5'h04, 5'h04, 5'h04, 5'h04, 5'h04, 5'h04};
      6'd31: g = {5'h11, 5'h11, 5'h11, 5'h11, 5'h11, 5'h11, 5'h0E};
      6'd32: g = {5'h11, 5'h11, 5'h11, 5'h11, 5'h11, 5'h0A, 5'h04};
      6'd33: g = {5'h11, 5'h11, 5'h11, 5'h15, 5'h15, 5'h15, 5'h0A};
      6'd34: g = {5'h11, 5'h11, 5'h0A, 5'h04, 5'h0A, 5'h11, 5'h11};
      6'd35: g = {5'h11, 5'h11, 5'h11, 5'h0A, 5'h04, 5'h04, 5'h04};
      6'd36: g = {5'h1F, 5'h01, 5'h02, 5'h04, 5'h08, 5'h10, 5'h1F};
      6'd37: g = {5'h00, 5'h00, 5'h00, 5'h00, 5'h00, 5'h0C, 5'h0C};
      6'd38: g = {5'h00, 5'h00, 5'h00, 5'h1F, 5'h00, 5'h00, 5'h00};
      6'd39: g = {5'h00, 5'h0C, 5'h0C, 5'h00, 5'h0C, 5'h0C, 5'h00};
      default: g = '0;
    endcase
    return g;
  endfunction

  logic [11:0] pos_x_q, pos_y_q;
  logic [5:0]  code_q [NCHAR];
  logic        s1_hit_q, s1_hit_d;
  logic [5:0]  s1_code_q, s1_code_d;
  logic [2:0]  s1_row_q, s1_row_d;
  logic [2:0]  s1_col_q, s1_col_d;
  logic        cond_q, cond_d;

  // All bounds are 13 bits wide so a glyph running past column 4095 is
  // simply cut off instead of wrapping back to column 0.
  logic [12:0] x13, y13, px13, py13, dy, lo, dx;
  logic        hit_x, hit_y;

  assign x13   = {1'b0, VGA_horzCoord};
  assign y13   = {1'b0, VGA_vertCoord};
  assign px13  = {1'b0, pos_x_q};
  assign py13  = {1'b0, pos_y_q};
  assign dy    = y13 - py13;
  assign hit_y = (y13 >= py13) && (dy < GLYPH_H);

  always_comb begin
    hit_x     = 1'b0;
    s1_code_d = '0;
    s1_col_d  = '0;
    lo        = '0;
    dx        = '0;
    for (int k = 0; k < NCHAR; k++) begin
      lo = px13 + 13'(k * PITCH);
      dx = x13 - lo;
      if ((x13 >= lo) && (dx < GLYPH_W)) begin
        hit_x     = 1'b1;
        s1_code_d = code_q[k];
        s1_col_d  = 3'(dx >> SCALE_LOG2);
      end
    end
    s1_hit_d = hit_x && hit_y;
    s1_row_d = hit_y ? 3'(dy >> SCALE_LOG2) : 3'd0;
  end

  // Stage 2 glyph lookup. Stage 1 captures the slot's code rather than its
  // index, so a label write landing while a pixel is in flight cannot
  // change what that pixel shows.
  logic [34:0] glyph_bits;
  logic [4:0]  row_bits;
  logic        pix;

  always_comb begin
    glyph_bits = glyph(s1_code_q);
    case (s1_row_q)
      3'd0:    row_bits = glyph_bits[34:30];
      3'd1:    row_bits = glyph_bits[29:25];
      3'd2:    row_bits = glyph_bits[24:20];
      3'd3:    row_bits = glyph_bits[19:15];
      3'd4:    row_bits = glyph_bits[14:10];
      3'd5:    row_bits = glyph_bits[9:5];
      3'd6:    row_bits = glyph_bits[4:0];
      default: row_bits = '0;
    endcase
    pix = (s1_col_q < 3'd5) ? row_bits[3'd4 - s1_col_q] : 1'b0;
  end

`ifdef VGA_LABEL_BLINK_EN
  logic [BLINK_LOG2:0] frame_q;
  logic                s1_blank_q;

  // Frame count advances on the (0,0) pixel; the blank decision travels
  // through stage 1 alongside the coordinate it belongs to.
  always_ff @(posedge CLK) begin
    if (RESET) begin
      frame_q    <= '0;
      s1_blank_q <= 1'b0;
    end else begin
      if ((VGA_horzCoord == 12'd0) && (VGA_vertCoord == 12'd0))
        frame_q <= frame_q + (BLINK_LOG2 + 1)'(1);
      s1_blank_q <= BLINK & frame_q[BLINK_LOG2];
    end
  end

  assign cond_d = s1_hit_q & pix & ~s1_blank_q;
`else
  logic unused_blink;
  assign unused_blink = BLINK;
  assign cond_d       = s1_hit_q & pix;
`endif

  always_ff @(posedge CLK) begin
    if (RESET) begin
      pos_x_q   <= 12'(X0);
      pos_y_q   <= 12'(Y0);
      for (int k = 0; k < NCHAR; k++) code_q[k] <= '0;
      s1_hit_q  <= 1'b0;
      s1_code_q <= '0;
      s1_row_q  <= '0;
      s1_col_q  <= '0;
      cond_q    <= 1'b0;
    end else begin
      if (POS_WR) begin
        pos_x_q <= POS_X;
        pos_y_q <= POS_Y;
      end
      for (int k = 0; k < NCHAR; k++)
        if (LBL_WR && (LBL_IDX == 4'(k))) code_q[k] <= LBL_CODE;
      s1_hit_q  <= s1_hit_d;
      s1_code_q <= s1_code_d;
      s1_row_q  <= s1_row_d;
      s1_col_q  <= s1_col_d;
      cond_q    <= cond_d;
    end
  end

  assign CONDITION = cond_q;

endmodule

// File: tb/tb_vga_text_label.sv
// Testbench for vga_text_label: a default instance (dut0) and a 2x-scaled,
// fast-blink instance (dut1) share all inputs. Expected pixels come from a
// small geometric model plus the font rows of the glyphs used, queued at
// drive time and compared two cycles later.
module tb_vga_text_label;

  logic        clk = 1'b0;
  logic        rst;
  logic [11:0] hx, vy;
  logic        lbl_wr, pos_wr, blink;
  logic [3:0]  lbl_idx;
  logic [5:0]  lbl_code;
  logic [11:0] pos_x, pos_y;
  logic        cond0, cond1;

  always #5 clk = ~clk;

  vga_text_label dut0 (
    .CLK(clk), .RESET(rst), .VGA_horzCoord(hx), .VGA_vertCoord(vy),
    .LBL_WR(lbl_wr), .LBL_IDX(lbl_idx), .LBL_CODE(lbl_code),
    .POS_WR(pos_wr), .POS_X(pos_x), .POS_Y(pos_y), .BLINK(blink),
    .CONDITION(cond0)
  );

  vga_text_label #(.SCALE_LOG2(1), .BLINK_LOG2(1)) dut1 (
    .CLK(clk), .RESET(rst), .VGA_horzCoord(hx), .VGA_vertCoord(vy),
    .LBL_WR(lbl_wr), .LBL_IDX(lbl_idx), .LBL_CODE(lbl_code),
    .POS_WR(pos_wr), .POS_X(pos_x), .POS_Y(pos_y), .BLINK(blink),
    .CONDITION(cond1)
  );

`ifdef VGA_LABEL_BLINK_EN
  localparam bit BLINK_BUILD = 1'b1;
`else
  localparam bit BLINK_BUILD = 1'b0;
`endif

  typedef struct {
    int   x;
    int   y;
    logic sel;
    logic exp;
  } sb_t;

  sb_t sbq[$];
  int  n_tests = 0;
  int  n_fail  = 0;
  int  m_code[4];
  int  m_ox, m_oy;

  function automatic logic [34:0] font(int c);
    case (c)
      14:      return {5'h1C, 5'h12, 5'h11, 5'h11, 5'h11, 5'h12, 5'h1C};
      19:      return {5'h0E, 5'h04, 5'h04, 5'h04, 5'h04, 5'h04, 5'h0E};
      32:      return {5'h11, 5'h11, 5'h11, 5'h11, 5'h11, 5'h0A, 5'h04};
      default: return '0;
    endcase
  endfunction

  function automatic logic model(int x, int y, int s);
    int dx, dy, p, k, cx, ry;
    logic [34:0] g;
    dx = x - m_ox;
    dy = y - m_oy;
    p  = 6 << s;
    if (dx < 0 || dy < 0) return 1'b0;
    k = dx / p;
    if (k >= 4) return 1'b0;
    cx = (dx % p) >> s;
    ry = dy >> s;
    if (cx > 4 || ry > 6) return 1'b0;
    g = font(m_code[k]);
    return g[34 - 5*ry - cx];
  endfunction

  function automatic void model_reset();
    for (int k = 0; k < 4; k++) m_code[k] = 0;
    m_ox = 208;
    m_oy = 940;
  endfunction

  task automatic drive(int x, int y);
    hx = 12'(x);
    vy = 12'(y);
  endtask

  task automatic push(int x, int y, logic sel);
    sb_t e;
    e.x = x; e.y = y; e.sel = sel;
    e.exp = model(x, y, sel ? 1 : 0);
    sbq.push_back(e);
  endtask

  task automatic wr_lbl(int idx, int code);
    @(negedge clk);
    lbl_wr = 1'b1; lbl_idx = 4'(idx); lbl_code = 6'(code);
    @(negedge clk);
    lbl_wr = 1'b0;
    if (idx < 4) m_code[idx] = code;
  endtask

  task automatic wr_pos(int x, int y);
    @(negedge clk);
    pos_wr = 1'b1; pos_x = 12'(x); pos_y = 12'(y);
    @(negedge clk);
    pos_wr = 1'b0;
    m_ox = x; m_oy = y;
  endtask

  task automatic do_reset();
    @(negedge clk);
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    model_reset();
  endtask

  // Reset with concurrent label/origin writes; outputs must stay dark.
  task automatic test_reset();
    sb_t e; logic got;
    int xs[5] = '{208, 209, 210, 100, 101};
    int ys[5] = '{940, 940, 941, 100, 100};
    rst = 1'b1; lbl_wr = 1'b1; lbl_idx = 4'd0; lbl_code = 6'd14;
    pos_wr = 1'b1; pos_x = 12'd100; pos_y = 12'd100;
    drive(208, 940);
    repeat (3) @(negedge clk);
    n_tests++;
    if (cond0 !== 1'b0) begin n_fail++; $display("FAIL reset_cond0 got=%b exp=0", cond0); end
    n_tests++;
    if (cond1 !== 1'b0) begin n_fail++; $display("FAIL reset_cond1 got=%b exp=0", cond1); end
    rst = 1'b0; lbl_wr = 1'b0; pos_wr = 1'b0;
    model_reset();
    for (int i = 0; i < 7; i++) begin
      @(negedge clk);
      if (i >= 2) begin
        e = sbq.pop_front(); got = e.sel ? cond1 : cond0; n_tests++;
        if (got !== e.exp) begin n_fail++; $display("FAIL after_reset x=%0d y=%0d got=%b exp=%b", e.x, e.y, got, e.exp); end
      end
      if (i < 5) begin drive(xs[i], ys[i]); push(xs[i], ys[i], 1'b0); end
      else drive(2000, 2000);
    end
  endtask

  task automatic test_single();
    sb_t e; logic got;
    int xs[6] = '{208, 207, 209, 211, 208, 212};
    int ys[6] = '{940, 940, 940, 940, 946, 946};
    wr_lbl(0, 14);
    for (int i = 0; i < 8; i++) begin
      @(negedge clk);
      if (i >= 2) begin
        e = sbq.pop_front(); got = e.sel ? cond1 : cond0; n_tests++;
        if (got !== e.exp) begin n_fail++; $display("FAIL single x=%0d y=%0d got=%b exp=%b", e.x, e.y, got, e.exp); end
      end
      if (i < 6) begin drive(xs[i], ys[i]); push(xs[i], ys[i], 1'b0); end
      else drive(2000, 2000);
    end
  endtask

  // "DIV" swept over its full box; gap columns 213/219/225 fall out dark.
  task automatic test_font_sweep();
    sb_t e; logic got;
    int n = 23 * 7;
    wr_lbl(1, 19);
    wr_lbl(2, 32);
    for (int i = 0; i < n + 2; i++) begin
      @(negedge clk);
      if (i >= 2) begin
        e = sbq.pop_front(); got = e.sel ? cond1 : cond0; n_tests++;
        if (got !== e.exp) begin n_fail++; $display("FAIL font_sweep x=%0d y=%0d got=%b exp=%b", e.x, e.y, got, e.exp); end
      end
      if (i < n) begin drive(208 + i % 23, 940 + i / 23); push(208 + i % 23, 940 + i / 23, 1'b0); end
      else drive(2000, 2000);
    end
  endtask

  // Out-of-range slot write, then label+origin written in the same cycle
  // as a pixel: that pixel sees old state, the next ones the new state.
  task automatic test_slot_writes();
    sb_t e; logic got;
    int n = 28;
    int x, y;
    wr_lbl(15, 14);
    for (int i = 0; i < n + 2; i++) begin
      @(negedge clk);
      if (i >= 2) begin
        e = sbq.pop_front(); got = e.sel ? cond1 : cond0; n_tests++;
        if (got !== e.exp) begin n_fail++; $display("FAIL slot_writes x=%0d y=%0d got=%b exp=%b", e.x, e.y, got, e.exp); end
      end
      if (i == 0) begin
        lbl_wr = 1'b1; lbl_idx = 4'd0; lbl_code = 6'd19;
        pos_wr = 1'b1; pos_x = 12'd300; pos_y = 12'd500;
        drive(208, 940); push(208, 940, 1'b0);
        m_code[0] = 19; m_ox = 300; m_oy = 500;
      end else if (i < n) begin
        lbl_wr = 1'b0; pos_wr = 1'b0;
        case (i)
          1:       begin x = 208; y = 940; end
          2:       begin x = 301; y = 500; end
          3:       begin x = 300; y = 500; end
          default: begin x = 300 + i - 4; y = 500; end
        endcase
        drive(x, y); push(x, y, 1'b0);
      end else drive(2000, 2000);
    end
  endtask

  // Reset concurrent with a label write: the write must not land.
  task automatic test_reset_write();
    sb_t e; logic got;
    int n = 48;
    @(negedge clk);
    rst = 1'b1; lbl_wr = 1'b1; lbl_idx = 4'd1; lbl_code = 6'd14;
    pos_wr = 1'b1; pos_x = 12'd4000; pos_y = 12'd4000;
    @(negedge clk);
    rst = 1'b0; lbl_wr = 1'b0; pos_wr = 1'b0;
    model_reset();
    wr_lbl(0, 14);
    for (int i = 0; i < n + 2; i++) begin
      @(negedge clk);
      if (i >= 2) begin
        e = sbq.pop_front(); got = e.sel ? cond1 : cond0; n_tests++;
        if (got !== e.exp) begin n_fail++; $display("FAIL reset_write x=%0d y=%0d got=%b exp=%b", e.x, e.y, got, e.exp); end
      end
      if (i < n) begin drive(208 + i % 24, 940 + 3 * (i / 24)); push(208 + i % 24, 940 + 3 * (i / 24), 1'b0); end
      else drive(2000, 2000);
    end
  endtask

  // Origin near the right edge: columns 4093..4095 draw, 0..4 stay dark.
  task automatic test_clip();
    sb_t e; logic got;
    int n = 11 * 7;
    int x, xi;
    do_reset();
    wr_lbl(0, 14);
    wr_lbl(1, 14);
    wr_pos(4093, 10);
    for (int i = 0; i < n + 2; i++) begin
      @(negedge clk);
      if (i >= 2) begin
        e = sbq.pop_front(); got = e.sel ? cond1 : cond0; n_tests++;
        if (got !== e.exp) begin n_fail++; $display("FAIL clip x=%0d y=%0d got=%b exp=%b", e.x, e.y, got, e.exp); end
      end
      if (i < n) begin
        xi = i % 11;
        x  = (xi < 6) ? 4090 + xi : xi - 6;
        drive(x, 10 + i / 11); push(x, 10 + i / 11, 1'b0);
      end else drive(2000, 2000);
    end
  endtask

  task automatic test_scale();
    sb_t e; logic got;
    int n = 14 * 16;
    do_reset();
    wr_lbl(0, 19);
    for (int i = 0; i < n + 2; i++) begin
      @(negedge clk);
      if (i >= 2) begin
        e = sbq.pop_front(); got = e.sel ? cond1 : cond0; n_tests++;
        if (got !== e.exp) begin n_fail++; $display("FAIL scale x=%0d y=%0d got=%b exp=%b", e.x, e.y, got, e.exp); end
      end
      if (i < n) begin drive(206 + i % 14, 939 + i / 14); push(206 + i % 14, 939 + i / 14, 1'b1); end
      else drive(2000, 2000);
    end
  endtask

  // Each frame: one lit label pixel, then the (0,0) frame marker.
  task automatic test_blink();
    sb_t e; logic got;
    int n = 12;
    int f;
    do_reset();
    wr_lbl(0, 19);
    blink = 1'b1;
    for (int i = 0; i < n + 2; i++) begin
      @(negedge clk);
      if (i >= 2) begin
        e = sbq.pop_front(); got = e.sel ? cond1 : cond0; n_tests++;
        if (got !== e.exp) begin n_fail++; $display("FAIL blink x=%0d y=%0d got=%b exp=%b", e.x, e.y, got, e.exp); end
      end
      if (i < n) begin
        f = i / 2;
        if (i % 2 == 0) begin
          drive(212, 940); push(212, 940, 1'b1);
          if (BLINK_BUILD && (f % 4) >= 2) sbq[sbq.size() - 1].exp = 1'b0;
        end else begin
          drive(0, 0); push(0, 0, 1'b1);
        end
      end else drive(2000, 2000);
    end
    blink = 1'b0;
  endtask

  initial begin
    rst = 1'b1; lbl_wr = 1'b0; pos_wr = 1'b0; blink = 1'b0;
    lbl_idx = '0; lbl_code = '0; pos_x = '0; pos_y = '0;
    hx = 12'd2000; vy = 12'd2000;
    model_reset();
    test_reset();
    test_single();
    test_font_sweep();
    test_slot_writes();
    test_reset_write();
    test_clip();
    test_scale();
    test_blink();
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog timeout tests=%0d", n_tests);
    $fatal(1);
  end

endmodule

// File: doc/vga_text_label.md
VGA_TEXT_LABEL -- requirements
Module: vga_text_label

Interface
REQ-001 SHALL have parameter NCHAR, default 4, number of character slots (1..16).
REQ-002 SHALL have parameter SCALE_LOG2, default 0, glyph magnification 2^SCALE_LOG2 (0..2).
REQ-003 SHALL have parameter CHAR_GAP, default 1, unscaled blank columns between glyphs.
REQ-004 SHALL have parameter X0, default 208, reset horizontal origin.
REQ-005 SHALL have parameter Y0, default 940, reset vertical origin.
REQ-006 SHALL have parameter BLINK_LOG2, default 5, blink half-period is 2^BLINK_LOG2 frames.
REQ-007 SHALL have port CLK  input  1  pixel clock; the only clock.
REQ-008 SHALL have port RESET  input  1  synchronous, active-high reset.
REQ-009 SHALL have port VGA_horzCoord  input  12  current pixel column.
REQ-010 SHALL have port VGA_vertCoord  input  12  current pixel row.
REQ-011 SHALL have port LBL_WR  input  1  write strobe for one character slot.
REQ-012 SHALL have port LBL_IDX  input  4  slot index for LBL_WR.
REQ-013 SHALL have port LBL_CODE  input  6  character code for LBL_WR.
REQ-014 SHALL have port POS_WR  input  1  origin write strobe.
REQ-015 SHALL have port POS_X  input  12  new horizontal origin.
REQ-016 SHALL have port POS_Y  input  12  new vertical origin.
REQ-017 SHALL have port BLINK  input  1  blink request (used only with the blink feature).
REQ-018 SHALL have port CONDITION  output  1  registered pixel-on flag for the label.

Function
REQ-019 SHALL use 5x7 unscaled glyphs; codes: 0 space, 1-10 digits '0'-'9', 11-36 'A'-'Z', 37 '.', 38 '-', 39 ':'; codes 40-63 render blank.
REQ-020 SHALL define pitch P = (5+CHAR_GAP)<<SCALE_LOG2; slot k covers x in [X+k*P, X+k*P+(5<<SCALE_LOG2)-1] and y in [Y, Y+(7<<SCALE_LOG2)-1].
REQ-021 SHALL select glyph column (x-X-k*P)>>SCALE_LOG2 and row (y-Y)>>SCALE_LOG2; gap columns are never lit.
REQ-022 SHALL compute all bounds in 13 bits; any pixel whose bound exceeds 4095 is clipped, never wrapped to column 0.
REQ-023 SHALL be a 2-stage pipeline: stage 1 registers hit, slot, row and column; stage 2 registers the glyph bit into CONDITION; latency exactly 2 CLK cycles from coordinate to output.
REQ-024 SHALL write LBL_CODE into slot LBL_IDX on a cycle with LBL_WR=1; LBL_IDX >= NCHAR is ignored.
REQ-025 SHALL load origin from POS_X/POS_Y on a cycle with POS_WR=1.
REQ-026 SHALL make writes visible to coordinates sampled on the cycle after the write; coordinates already in the pipeline use old values.
REQ-027 SHALL apply LBL_WR and POS_WR together when both are asserted in the same cycle.

Reset
REQ-028 SHALL, when RESET=1 at a CLK edge, clear CONDITION and both pipeline stages to 0, load origin to (X0,Y0), and set every slot to code 0.
REQ-029 SHALL give RESET priority over LBL_WR and POS_WR asserted in the same cycle.
REQ-030 SHALL output CONDITION=0 for the 2 cycles after RESET deasserts (pipeline flushed).

Configuration
REQ-031 SHALL, with VGA_LABEL_BLINK_EN defined, count frames in a BLINK_LOG2+1-bit counter that increments when sampled coords are (0,0), resets to 0, and wraps.
REQ-032 SHALL, with VGA_LABEL_BLINK_EN defined, force CONDITION=0 while BLINK=1 and counter MSB=1, aligned to the same pipeline timing.
REQ-033 SHALL, without VGA_LABEL_BLINK_EN, omit the counter and ignore BLINK.

Verification
REQ-034 SHALL cover: reset, slot0=14 ('D'), coords (208,940) -> CONDITION=1 two cycles later; (207,940) -> 0.
REQ-035 SHALL cover: slots "DIV", sweep x=208..230, y=940..946 -> lit map equals font table; gap columns 213, 219, 225 -> 0.
REQ-036 SHALL cover: POS_WR to (4093,10) -> pixels at x>4095 not lit, x=0..4 at y=10 -> 0.
REQ-037 SHALL cover: LBL_WR with LBL_IDX=15, NCHAR=4 -> slots unchanged; RESET with LBL_WR -> all slots 0.
REQ-038 SHALL cover: SCALE_LOG2=1, slot0='I' -> each lit source pixel appears as 2x2 block, origin unchanged.
REQ-039 SHALL cover (blink build): BLINK=1, BLINK_LOG2=1 -> label lit frames 0-1, dark 2-3, lit 4-5.
